// File: rtl/multisim_pkg.sv
// Shared constants and helpers for the multisim client FIFO.
package multisim_pkg;

  localparam int STAT_W = 32;

  // Bits needed to hold any value in 0..n (occupancy counters).
  function automatic int clog2_plus1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < (n + 1)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/multisim_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module multisim_fifo_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Combinational read gives first-word-fall-through at the top level.
  assign rdata = r_mem[raddr];

endmodule

// File: rtl/multisim_client_fifo.sv
// Elastic valid/ready buffer feeding the multisim client, with occupancy and
// high-watermark. Define MULTISIM_CLIENT_FIFO_STATS_EN for transfer/stall counters.
module multisim_client_fifo
  import multisim_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          data_vld,
  input  logic                          data_rdy,
  output logic [DATA_WIDTH-1:0]         data,
  output logic [clog2_plus1(DEPTH)-1:0] level,
  output logic [clog2_plus1(DEPTH)-1:0] max_level
`ifdef MULTISIM_CLIENT_FIFO_STATS_EN
  ,
  output logic [STAT_W-1:0]             xfer_count,
  output logic [STAT_W-1:0]             stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = clog2_plus1(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "multisim_client_fifo: DEPTH must be a power of two >= 2");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] r_max_level;
  logic [LW-1:0] w_level_next;
  logic          w_push;
  logic          w_pop;

  assign in_rdy    = !rst && (r_level != LW'(DEPTH));
  assign data_vld  = !rst && (r_level != '0);
  assign w_push    = in_vld && in_rdy;
  assign w_pop     = data_vld && data_rdy;
  assign level     = r_level;
  assign max_level = r_max_level;

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_max_level <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_next;
      if (w_level_next > r_max_level) r_max_level <= w_level_next;
    end
  end

  multisim_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (w_push),
    .waddr(r_wr_ptr),
    .wdata(in_data),
    .raddr(r_rd_ptr),
    .rdata(data)
  );

`ifdef MULTISIM_CLIENT_FIFO_STATS_EN
  logic [STAT_W-1:0] r_xfer_count;
  logic [STAT_W-1:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop && r_xfer_count != '1) r_xfer_count <= r_xfer_count + STAT_W'(1);
      if (data_vld && !data_rdy && r_stall_count != '1)
        r_stall_count <= r_stall_count + STAT_W'(1);
    end
  end

  assign xfer_count  = r_xfer_count;
  assign stall_count = r_stall_count;

  final $display("multisim_client_fifo: xfers=%0d stalls=%0d", r_xfer_count, r_stall_count);
`endif

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && r_level == LW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(w_pop && r_level == '0));
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (data_vld && !data_rdy) |=> (data_vld && $stable(data)));

endmodule
